// File: rtl/bus2_rx_pkg.sv
// bus2_rx_pkg: shared types and constants for the 2-bit lane receive path.
//   LANE_W          : width of one lane beat (2 bits)
//   bus2_rx_state_t : receive FSM states (COLLECT, PARITY)
//   BUS2_BEATS()    : number of lane beats that make up one word
package bus2_rx_pkg;

  localparam int LANE_W = 2;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } bus2_rx_state_t;

  function automatic int BUS2_BEATS(input int word_w);
    return word_w / LANE_W;
  endfunction

endpackage

// File: rtl/bus2_rx_deserializer_if.sv
// bus2_rx_deserializer_if: lane input and word output signals of the
// deserializer, bundled as one interface.
//   lane_valid/lane_data/lane_sync : 2-bit beat stream from the tile array
//   word_valid/word_ready/word_data: word handshake towards the consumer
//   fifo_level                     : words currently buffered
//   overflow/parity_err            : one-cycle status pulses
// Modports: slave = deserializer side, master = lane driver / consumer side.
interface bus2_rx_deserializer_if #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4
) ();
  import bus2_rx_pkg::*;

  logic                        lane_valid;
  logic [LANE_W-1:0]           lane_data;
  logic                        lane_sync;
  logic                        word_valid;
  logic                        word_ready;
  logic [WORD_W-1:0]           word_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        overflow;
  logic                        parity_err;

  modport slave (
    input  lane_valid, lane_data, lane_sync, word_ready,
    output word_valid, word_data, fifo_level, overflow, parity_err
  );

  modport master (
    output lane_valid, lane_data, lane_sync, word_ready,
    input  word_valid, word_data, fifo_level, overflow, parity_err
  );

endinterface

// File: rtl/bus2_rx_fifo.sv
// bus2_rx_fifo: synchronous word FIFO with combinational head read.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push_i     : write data_i; accepted when not full, or full with a pop
//   data_i     : word to write
//   pop_i      : consumer takes the head (ignored while empty)
//   full_o     : DEPTH words stored
//   empty_o    : no words stored
//   level_o    : number of stored words
//   head_o     : oldest word, forced to 0 while empty
module bus2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  // The extra MSB on each pointer separates full (MSBs differ) from empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries no reset; the empty gate on head_o hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= data_i;
  end

  assign head_o = empty_o ? '0 : mem[rd_q[AW-1:0]];

endmodule

// File: rtl/bus2_rx_deserializer.sv
// bus2_rx_deserializer: collects 2-bit lane beats LSB-first into WORD_W-bit
// words and buffers them in a small FIFO for the downstream consumer.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bus2_rx_deserializer_if.slave (lane input, word output, status)
// Optional feature macro BUS2_RX_PARITY_EN: each word is followed by a parity
// beat {reserved, p} with p the even parity of the word; mismatching words are
// dropped and parity_err pulses. Without the macro parity_err is tied to 0.
module bus2_rx_deserializer
  import bus2_rx_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bus2_rx_deserializer_if.slave  bus
);

  localparam int BEATS = BUS2_BEATS(WORD_W);
  localparam int CNT_W = $clog2(BEATS);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  bus2_rx_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] push_word;
  logic              push;
  logic              ovf_q, ovf_d;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [WORD_W-1:0] fifo_head;
`ifdef BUS2_RX_PARITY_EN
  logic              perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    push      = 1'b0;
    push_word = word_q;
`ifdef BUS2_RX_PARITY_EN
    perr_d    = 1'b0;
`endif
    if (bus.lane_sync) begin
      // Realign: the partial word is discarded; a beat arriving now opens
      // the next word as beat 0.
      state_d = COLLECT;
      cnt_d   = '0;
      word_d  = '0;
      if (bus.lane_valid) begin
        word_d[LANE_W-1:0] = bus.lane_data;
        cnt_d              = CNT_W'(1);
      end
    end else if (bus.lane_valid) begin
      case (state_q)
        COLLECT: begin
          word_d[cnt_q*LANE_W +: LANE_W] = bus.lane_data;
          if (cnt_q == LAST_BEAT) begin
            cnt_d = '0;
`ifdef BUS2_RX_PARITY_EN
            state_d = PARITY;
`else
            push      = 1'b1;
            push_word = word_d;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef BUS2_RX_PARITY_EN
        PARITY: begin
          // Only bit 0 of the parity beat carries p; bit 1 is reserved.
          state_d = COLLECT;
          cnt_d   = '0;
          if (bus.lane_data[0] == ^word_q) push   = 1'b1;
          else                             perr_d = 1'b1;
        end
`endif
        default: state_d = COLLECT;
      endcase
    end
  end

  // A full FIFO is never empty, so a pop is pending exactly when ready is high.
  assign ovf_d = push && fifo_full && !bus.word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BUS2_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef BUS2_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Assembly register carries no reset: every bit is rewritten before a push.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  bus2_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_word),
    .pop_i   (bus.word_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level),
    .head_o  (fifo_head)
  );

  assign bus.word_valid = !fifo_empty;
  assign bus.word_data  = fifo_head;
  assign bus.fifo_level = fifo_level;
  assign bus.overflow   = ovf_q;
`ifdef BUS2_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus2_rx_deserializer.sv
// Testbench for bus2_rx_deserializer (WORD_W=8, FIFO_DEPTH=4).
module tb_bus2_rx_deserializer;
  import bus2_rx_pkg::*;

  localparam int WORD_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BEATS      = WORD_W / 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus2_rx_deserializer_if #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  bus2_rx_deserializer #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       s;
    logic       r;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] el;
    logic       eo;
    logic       ep;
  } vec_t;

  vec_t tbl[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                         input logic [2:0] el, input logic eo, input logic ep);
    chk($sformatf("%s.word_valid", tag), 32'(bus.word_valid), 32'(ev));
    chk($sformatf("%s.word_data", tag),  32'(bus.word_data),  32'(ed));
    chk($sformatf("%s.fifo_level", tag), 32'(bus.fifo_level), 32'(el));
    chk($sformatf("%s.overflow", tag),   32'(bus.overflow),   32'(eo));
    chk($sformatf("%s.parity_err", tag), 32'(bus.parity_err), 32'(ep));
  endtask

  // Drive one cycle of inputs, let the edge sample them, return 1 time unit later.
  task automatic step(input logic v, input logic [1:0] d, input logic s, input logic r);
    bus.lane_valid = v;
    bus.lane_data  = d;
    bus.lane_sync  = s;
    bus.word_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [1:0] d, input logic s, input logic r,
                     input logic ev, input logic [7:0] ed, input logic [2:0] el);
    vec_t t;
    t.v = v; t.d = d; t.s = s; t.r = r;
    t.ev = ev; t.ed = ed; t.el = el; t.eo = 1'b0; t.ep = 1'b0;
    tbl.push_back(t);
  endtask

  // Final beat of a word that lands in an empty FIFO with ready high.
  task automatic add_last(input logic [1:0] d, input logic [7:0] word);
`ifdef BUS2_RX_PARITY_EN
    add(1'b1, d, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, {1'b0, ^word}, 1'b0, 1'b1, 1'b1, word, 3'd1);
`else
    add(1'b1, d, 1'b0, 1'b1, 1'b1, word, 3'd1);
`endif
  endtask

  // Send all beats of a word with ready low; the word-completing beat uses rdy_last.
  task automatic send_word(input logic [7:0] w, input logic rdy_last);
    logic [7:0] wv;
    int n;
    wv = w;
`ifdef BUS2_RX_PARITY_EN
    n = BEATS + 1;
`else
    n = BEATS;
`endif
    for (int i = 0; i < n; i++) begin
      logic [1:0] b;
      if (i < BEATS) b = wv[2*i +: 2];
      else           b = {1'b0, ^wv};
      step(1'b1, b, 1'b0, (i == n - 1) ? rdy_last : 1'b0);
    end
  endtask

  logic [7:0] ws [5];
  logic [7:0] fp [5];

  initial begin
    rst_n          = 1'b0;
    bus.lane_valid = 1'b0;
    bus.lane_data  = 2'b00;
    bus.lane_sync  = 1'b0;
    bus.word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk_out("post_reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Back-to-back beats 01,10,11,00 -> 8'h39, popped the cycle after.
    add(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add_last(2'b00, 8'h39);
    add(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    // Gaps between beats hold state and produce nothing.
    add(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add_last(2'b00, 8'h39);
    add(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    // Sync with a beat restarts the word at beat 0.
    add(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add_last(2'b00, 8'h39);
    add(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eo, tbl[i].ep);
    end

    // Five words into a stalled FIFO: the fifth overflows.
    ws[0] = 8'h39; ws[1] = 8'hA5; ws[2] = 8'h0F; ws[3] = 8'hC3; ws[4] = 8'h7E;
    for (int k = 0; k < 4; k++) begin
      send_word(ws[k], 1'b0);
      chk_out($sformatf("fill%0d", k), 1'b1, ws[0], 3'(k + 1), 1'b0, 1'b0);
    end
    send_word(ws[4], 1'b0);
    chk_out("ovf_pulse", 1'b1, ws[0], 3'd4, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk_out("ovf_end", 1'b1, ws[0], 3'd4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d.valid", k), 32'(bus.word_valid), 32'(1));
      chk($sformatf("drain%0d.data", k), 32'(bus.word_data), 32'(ws[k]));
      step(1'b0, 2'b00, 1'b0, 1'b1);
    end
    chk_out("drained", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Full FIFO, completing beat coincides with a pop: word accepted.
    fp[0] = 8'h12; fp[1] = 8'h34; fp[2] = 8'h56; fp[3] = 8'h78; fp[4] = 8'h9A;
    for (int k = 0; k < 4; k++) send_word(fp[k], 1'b0);
    chk_out("full", 1'b1, fp[0], 3'd4, 1'b0, 1'b0);
    send_word(fp[4], 1'b1);
    chk_out("push_pop_full", 1'b1, fp[1], 3'd4, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("push_pop_full.no_ovf", 32'(bus.overflow), 32'(0));
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("drain_pp%0d.data", k), 32'(bus.word_data), 32'(fp[k]));
      step(1'b0, 2'b00, 1'b0, 1'b1);
    end
    chk_out("drained_pp", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Reset with words stored and a partial word in flight discards everything.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(8'h5A, 1'b1);
    chk_out("after_reset_word", 1'b1, 8'h5A, 3'd1, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk_out("after_reset_pop", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

`ifdef BUS2_RX_PARITY_EN
    // 8'h39 has four ones: parity beat 00 accepts, 01 rejects.
    step(1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    chk_out("par_wait", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    chk_out("par_ok", 1'b1, 8'h39, 3'd1, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk_out("par_bad", 1'b1, 8'h39, 3'd1, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk_out("par_bad_end", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
